// File: rtl/shift_add_mul5.sv
// shift_add_mul5: sequential 5x5 unsigned shift-and-add multiplier.
// One ripple-add step per clock; start/busy/done handshake.
module shift_add_mul5 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_start,
  input  logic [4:0] in_a,
  input  logic [4:0] in_b,
  output logic [9:0] out_p,
  output logic       out_busy,
  output logic       out_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_a;
  logic [4:0] r_h;
  logic [4:0] r_l;
  logic [2:0] r_cnt;
  logic [9:0] r_p;

  logic [4:0] w_addend;
  logic [4:0] w_s;
  logic       w_c;
  logic       w_last;

  assign w_addend = r_l[0] ? r_a : 5'd0;
  assign w_last   = (r_cnt == 3'd4);

  // 5-bit ripple-carry adder, carry-in tied to 0
  always_comb begin
    logic c;
    c   = 1'b0;
    w_s = '0;
    for (int i = 0; i < 5; i++) begin
      w_s[i] = r_h[i] ^ w_addend[i] ^ c;
      c = (r_h[i] & w_addend[i]) |
          (c & (r_h[i] ^ w_addend[i]));
    end
    w_c = c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_h   <= '0;
      r_l   <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            r_a   <= in_a;
            r_h   <= '0;
            r_l   <= in_b;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          // carry-out lands in H[4]; {H,L} shifts right one bit
          r_h   <= {w_c, w_s[4:1]};
          r_l   <= {w_s[0], r_l[4:1]};
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_p <= {w_c, w_s, r_l[4:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign out_p    = r_p;
  assign out_busy = (r_state == S_RUN);
  assign out_done = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_add_mul5.sv
// tb_shift_add_mul5: randomized and directed bench for shift_add_mul5.
// Reference: product = a*b, fixed 5-cycle busy then 1-cycle done.
module tb_shift_add_mul5;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_start;
  logic [4:0] in_a;
  logic [4:0] in_b;
  logic [9:0] out_p;
  logic       out_busy;
  logic       out_done;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] exp_p;

  always #5 clk = ~clk;

  shift_add_mul5 dut (
    .clk      (clk),
    .reset    (reset),
    .in_start (in_start),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_p    (out_p),
    .out_busy (out_busy),
    .out_done (out_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // One operation: start pulse, scramble inputs, check timing and result
  task automatic do_mul(input int a, input int b);
    @(negedge clk);
    in_a     = 5'(a);
    in_b     = 5'(b);
    in_start = 1'b1;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    in_a     = 5'($urandom);
    in_b     = 5'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_run", out_busy, 1);
      check("done_run", out_done, 0);
      check("p_hold", out_p, exp_p);
    end
    exp_p = 10'(a * b);
    @(negedge clk);
    check("done_pulse", out_done, 1);
    check("busy_done", out_busy, 0);
    check("product", out_p, a * b);
    @(negedge clk);
    check("done_clear", out_done, 0);
    check("busy_idle", out_busy, 0);
    check("p_idle", out_p, exp_p);
  endtask

  initial begin
    reset    = 1'b1;
    in_start = 1'b0;
    in_a     = '0;
    in_b     = '0;
    exp_p    = '0;
    repeat (2) @(negedge clk);
    check("rst_p", out_p, 0);
    check("rst_busy", out_busy, 0);
    check("rst_done", out_done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", out_busy, 0);
    check("idle_done", out_done, 0);

    do_mul(13, 11);
    do_mul(31, 31);
    do_mul(31, 1);
    do_mul(0, 27);
    do_mul(19, 0);

    // start held high: one product per 7 cycles, start ignored in RUN/DONE
    @(negedge clk);
    in_a     = 5'd5;
    in_b     = 5'd6;
    in_start = 1'b1;
    for (int j = 1; j <= 28; j++) begin
      @(negedge clk);
      if (j == 2) begin
        in_a = 5'd31;
        in_b = 5'd31;
      end
      if (j == 4) begin
        in_a = 5'd5;
        in_b = 5'd6;
      end
      check("held_done", out_done, (j % 7 == 6) ? 1 : 0);
      check("held_busy", out_busy,
            (j % 7 >= 1 && j % 7 <= 5) ? 1 : 0);
      if (j >= 6) exp_p = 10'd30;
      check("held_p", out_p, exp_p);
      if (j == 28) in_start = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("held_stop", out_busy, 0);

    // reset mid-RUN discards the partial result
    do_mul(9, 9);
    @(negedge clk);
    in_a     = 5'd7;
    in_b     = 5'd3;
    in_start = 1'b1;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", out_busy, 1);
    check("pre_rst_p", out_p, 81);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_p = '0;
    check("mid_rst_p", out_p, 0);
    check("mid_rst_busy", out_busy, 0);
    check("mid_rst_done", out_done, 0);
    @(negedge clk);
    check("post_rst_idle", out_busy, 0);
    do_mul(7, 3);

    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        do_mul(a, b);
      end
    end

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("gap_busy", out_busy, 0);
        check("gap_p", out_p, exp_p);
      end
      do_mul(int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
